seq_pattern_detector: RTL



---
 rtl/seq_pattern_detector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// Purpose : serial bit-pattern detector with runtime-loadable pattern/length,
//           overlapping or non-overlapping detection, optional match counter.
// Latency : match is registered, high in the cycle after the completing bit.
// Backpr. : none; a bit is consumed on every in_valid cycle (cfg_load wins).
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     in_bit is sampled on this edge
//   in_bit       serial data bit
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   cfg_load     load cfg_pattern / cfg_len; clears history and fill
//   cfg_pattern  new pattern, right-aligned; cfg_pattern[len-1] arrives first
//   cfg_len      new length, clamped to 1..MAX_LEN
//   match        one-cycle pulse when a match completes
//   armed        history holds at least len valid bits
//   match_count  saturating match counter
//
// Build option: define MATCH_COUNT_EN to compile in the match counter;
// otherwise match_count is tied to zero.

module seq_pattern_detector #(
    parameter int                 MAX_LEN         = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 16'b0000_1110_1101_1011,
    parameter int                 DEFAULT_LEN     = 12,
    parameter int                 COUNT_W         = 8,
    localparam int                LW              = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    output logic               match,
    output logic               armed,
    output logic [COUNT_W-1:0] match_count
);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    localparam logic [LW-1:0] LEN_RST = LW'(DEFAULT_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_inc;
    logic [LW-1:0]      len_clamped;
    logic               hit;

    // Newest bit enters at hist[0]; the oldest bits fall off the top.
    assign hist_next = {hist[MAX_LEN-2:0], in_bit};

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                len_mask[i] = 1'b1;
            end
        end
    end

    // fill saturates at len so it can never overrun the active length.
    always_comb begin
        fill_inc = fill;
        if (fill < len) begin
            fill_inc = fill + LW'(1);
        end
    end

    assign hit = (fill_inc >= len) && (((hist_next ^ pat) & len_mask) == '0);

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LW'(1);
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // Fill/armed state machine. state and armed carry the same decode
    // (fill == len); armed is the registered copy presented on the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FILL;
            pat   <= DEFAULT_PATTERN;
            len   <= LEN_RST;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
            armed <= 1'b0;
        end else if (cfg_load) begin
            // A coincident in_valid bit is dropped: the new pattern starts clean.
            state <= S_FILL;
            pat   <= cfg_pattern;
            len   <= len_clamped;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
            armed <= 1'b0;
        end else if (in_valid) begin
            hist  <= hist_next;
            match <= hit;
            if (hit && !overlap) begin
                // Non-overlapping: the next match needs len fresh bits.
                state <= S_FILL;
                fill  <= '0;
                armed <= 1'b0;
            end else begin
                fill <= fill_inc;
                if (fill_inc == len) begin
                    state <= S_ARMED;
                    armed <= 1'b1;
                end else begin
                    state <= S_FILL;
                    armed <= 1'b0;
                end
            end
        end else begin
            match <= 1'b0;
        end
    end

`ifdef MATCH_COUNT_EN
    // Counts in step with the match register: increments on the edge that
    // raises match, and sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_count <= '0;
        end else if (!cfg_load && in_valid && hit && (match_count != '1)) begin
            match_count <= match_count + COUNT_W'(1);
        end
    end
`else
    assign match_count = '0;
`endif

endmodule
